// File: rtl/arp_frame_gen.sv
// arp_frame_gen: builds one 42-byte Ethernet ARP request/reply frame and
// streams it as 32-bit words (first byte in [31:24]) into the MAC ff_tx port.
// All addressing fields are captured on an accepted start, so upstream
// registers may change while the frame is in flight.
// Optional build macro ARP_FRAME_PAD_EN: pads the frame to the 60-byte
// Ethernet minimum (15 words, mod 0) instead of leaving it to the MAC.
module arp_frame_gen #(
  parameter logic [15:0] ETHERTYPE_ARP = 16'h0806,
  parameter int          FRAME_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_oper,
  input  logic [47:0]            i_self_mac,
  input  logic [31:0]            i_self_ip,
  input  logic [47:0]            i_dst_mac,
  input  logic [47:0]            i_target_mac,
  input  logic [31:0]            i_target_ip,
  output logic [31:0]            o_data,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [1:0]             o_mod,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

`ifdef ARP_FRAME_PAD_EN
  localparam logic [3:0] LAST_IDX = 4'd14;
  localparam logic [1:0] LAST_MOD = 2'd0;
`else
  localparam logic [3:0] LAST_IDX = 4'd10;
  localparam logic [1:0] LAST_MOD = 2'd2;
`endif

  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q;
  logic                   err_q;
  logic [FRAME_CNT_W-1:0] cnt_q;

  logic [47:0] dst_q, sha_q, tha_q;
  logic [31:0] spa_q, tpa_q;
  logic [1:0]  oper_q;

  logic        oper_ok, can_start, accept, reject, xfer, last;
  logic [31:0] word;

  assign oper_ok   = (i_oper == 2'd1) || (i_oper == 2'd2);
  assign can_start = i_start && (state_q != SEND);
  assign accept    = can_start && oper_ok;
  assign reject    = can_start && !oper_ok;
  assign xfer      = (state_q == SEND) && i_rdy;
  assign last      = (idx_q == LAST_IDX);

  // Next-state logic: starts are only honoured outside SEND, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SEND : IDLE;
      SEND:    state_d = (xfer && last) ? DONE : SEND;
      DONE:    state_d = accept ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, word index, error pulse and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept)
        idx_q <= 4'd0;
      else if (xfer)
        idx_q <= last ? 4'd0 : idx_q + 4'd1;
      if (xfer && last)
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Field capture on an accepted start; a request always carries a zero THA
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_q  <= i_dst_mac;
      sha_q  <= i_self_mac;
      spa_q  <= i_self_ip;
      tpa_q  <= i_target_ip;
      oper_q <= i_oper;
      tha_q  <= (i_oper == 2'd1) ? 48'h0 : i_target_mac;
    end
  end

  // Word map; indices past 10 are the zero padding words
  always_comb begin
    word = 32'h0;
    case (idx_q)
      4'd0:    word = dst_q[47:16];
      4'd1:    word = {dst_q[15:0], sha_q[47:32]};
      4'd2:    word = sha_q[31:0];
      4'd3:    word = {ETHERTYPE_ARP, 16'h0001};
      4'd4:    word = {16'h0800, 8'h06, 8'h04};
      4'd5:    word = {14'b0, oper_q, sha_q[47:32]};
      4'd6:    word = sha_q[31:0];
      4'd7:    word = spa_q;
      4'd8:    word = tha_q[47:16];
      4'd9:    word = {tha_q[15:0], tpa_q[31:16]};
      4'd10:   word = {tpa_q[15:0], 16'h0000};
      default: word = 32'h0;
    endcase
  end

  assign o_vld       = (state_q == SEND);
  assign o_busy      = (state_q == SEND);
  assign o_data      = o_vld ? word : 32'h0;
  assign o_sop       = o_vld && (idx_q == 4'd0);
  assign o_eop       = o_vld && last;
  assign o_mod       = o_eop ? LAST_MOD : 2'd0;
  assign o_done      = (state_q == DONE);
  assign o_err       = err_q;
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_arp_frame_gen.sv
// tb_arp_frame_gen: directed bench for arp_frame_gen with hand-computed
// frame word tables; counter width reduced to 2 bits to reach wrap-around.
module tb_arp_frame_gen;

`ifdef ARP_FRAME_PAD_EN
  localparam int         NW   = 15;
  localparam logic [1:0] LMOD = 2'd0;
`else
  localparam int         NW   = 11;
  localparam logic [1:0] LMOD = 2'd2;
`endif

  localparam logic [47:0] SHA   = 48'h0023543C471B;
  localparam logic [31:0] SPA   = 32'h0A00000B;
  localparam logic [31:0] TPA   = 32'h0A00006F;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] PEER  = 48'h112233445566;

  localparam logic [31:0] REQ_W [0:10] = '{
    32'hFFFFFFFF, 32'hFFFF0023, 32'h543C471B, 32'h08060001, 32'h08000604,
    32'h00010023, 32'h543C471B, 32'h0A00000B, 32'h00000000, 32'h00000A00,
    32'h006F0000};
  localparam logic [31:0] REP_W [0:10] = '{
    32'h11223344, 32'h55660023, 32'h543C471B, 32'h08060001, 32'h08000604,
    32'h00020023, 32'h543C471B, 32'h0A00000B, 32'h11223344, 32'h55660A00,
    32'h006F0000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_oper = 2'd0;
  logic [47:0] i_self_mac = '0, i_dst_mac = '0, i_target_mac = '0;
  logic [31:0] i_self_ip = '0, i_target_ip = '0;
  logic        i_rdy = 1'b1;
  logic [31:0] o_data;
  logic        o_vld, o_sop, o_eop, o_busy, o_done, o_err;
  logic [1:0]  o_mod;
  logic [1:0]  o_frame_cnt;

  int nvec = 0;
  int nfail = 0;

  logic [31:0] cap_data [0:15];
  logic        cap_sop  [0:15];
  logic        cap_eop  [0:15];
  logic [1:0]  cap_mod  [0:15];
  int          cap_n, cap_done_cyc, cap_stall_bad, cap_err_cnt;

  arp_frame_gen #(.ETHERTYPE_ARP(16'h0806), .FRAME_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_oper(i_oper),
    .i_self_mac(i_self_mac), .i_self_ip(i_self_ip), .i_dst_mac(i_dst_mac),
    .i_target_mac(i_target_mac), .i_target_ip(i_target_ip),
    .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_sop(o_sop),
    .o_eop(o_eop), .o_mod(o_mod), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_frame_cnt(o_frame_cnt));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a one-cycle start; returns just after the edge that samples it
  task automatic do_start(input logic [1:0] oper, input logic [47:0] dst,
                          input logic [47:0] tha);
    i_start      = 1'b1;
    i_oper       = oper;
    i_self_mac   = SHA;
    i_self_ip    = SPA;
    i_dst_mac    = dst;
    i_target_mac = tha;
    i_target_ip  = TPA;
    step();
    i_start = 1'b0;
  endtask

  // Record accepted words until o_done (bounded); optionally re-pulse i_start
  task automatic capture(input bit rand_rdy, input int inject_cyc);
    logic [31:0] held;
    bit          holding;
    held = '0;
    holding = 1'b0;
    cap_n = 0; cap_done_cyc = 0; cap_stall_bad = 0; cap_err_cnt = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (o_err) cap_err_cnt++;
      if (o_done) begin
        cap_done_cyc = cyc;
        break;
      end
      if (holding && o_data !== held) cap_stall_bad++;
      i_rdy   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start = (cyc == inject_cyc);
      if (o_vld && i_rdy) begin
        if (cap_n < 16) begin
          cap_data[cap_n] = o_data;
          cap_sop[cap_n]  = o_sop;
          cap_eop[cap_n]  = o_eop;
          cap_mod[cap_n]  = o_mod;
        end
        cap_n++;
        holding = 1'b0;
      end else if (o_vld) begin
        holding = 1'b1;
        held    = o_data;
      end
      step();
    end
    i_start = 1'b0;
    i_rdy   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    nvec++;
    if ({o_data, o_vld, o_sop, o_eop, o_mod, o_busy, o_done, o_err, o_frame_cnt} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: data=%h vld=%b sop=%b eop=%b mod=%0d busy=%b done=%b err=%b cnt=%0d, all required 0",
               o_data, o_vld, o_sop, o_eop, o_mod, o_busy, o_done, o_err, o_frame_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_request();
    logic [31:0] exp;
    do_start(2'd1, BCAST, 48'hAABBCCDDEEFF);
    nvec++;
    if (!(o_vld && o_sop && o_busy)) begin
      nfail++;
      $display("FAIL req_latency: vld=%b sop=%b busy=%b, required 1 1 1", o_vld, o_sop, o_busy);
    end
    capture(1'b0, 0);
    nvec++;
    if (cap_n != NW) begin
      nfail++;
      $display("FAIL req_words: got %0d words, required %0d", cap_n, NW);
    end
    for (int i = 0; i < NW && i < cap_n; i++) begin
      exp = (i < 11) ? REQ_W[i] : 32'h0;
      nvec++;
      if (cap_data[i] !== exp || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == NW - 1)
          || cap_mod[i] !== ((i == NW - 1) ? LMOD : 2'd0)) begin
        nfail++;
        $display("FAIL req_word%0d: got %h sop=%b eop=%b mod=%0d, required %h sop=%b eop=%b mod=%0d",
                 i, cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i], exp, (i == 0), (i == NW - 1),
                 (i == NW - 1) ? LMOD : 2'd0);
      end
    end
    nvec++;
    if (cap_done_cyc != NW + 1) begin
      nfail++;
      $display("FAIL req_done_latency: o_done at cycle %0d, required %0d", cap_done_cyc, NW + 1);
    end
    nvec++;
    if (o_frame_cnt !== 2'd1 || o_vld !== 1'b0 || o_busy !== 1'b0) begin
      nfail++;
      $display("FAIL req_done_state: cnt=%0d vld=%b busy=%b, required 1 0 0", o_frame_cnt, o_vld, o_busy);
    end
    step();
    nvec++;
    if (o_done !== 1'b0) begin
      nfail++;
      $display("FAIL req_done_pulse: o_done=%b one cycle later, required 0", o_done);
    end
  endtask

  task automatic test_reply();
    do_start(2'd2, PEER, PEER);
    capture(1'b0, 0);
    nvec++;
    if (cap_n != NW || cap_data[0] !== REP_W[0] || cap_data[1] !== REP_W[1]
        || cap_data[5] !== REP_W[5] || cap_data[8] !== REP_W[8] || cap_data[9] !== REP_W[9]) begin
      nfail++;
      $display("FAIL reply_words: n=%0d w0=%h w1=%h w5=%h w8=%h w9=%h, required n=%0d %h %h %h %h %h",
               cap_n, cap_data[0], cap_data[1], cap_data[5], cap_data[8], cap_data[9],
               NW, REP_W[0], REP_W[1], REP_W[5], REP_W[8], REP_W[9]);
    end
    nvec++;
    if (o_frame_cnt !== 2'd2) begin
      nfail++;
      $display("FAIL reply_cnt: got %0d, required 2", o_frame_cnt);
    end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    logic [31:0] exp;
    bad = 0;
    do_start(2'd1, BCAST, PEER);
    capture(1'b1, 0);
    for (int i = 0; i < NW && i < cap_n; i++) begin
      exp = (i < 11) ? REQ_W[i] : 32'h0;
      if (cap_data[i] !== exp) bad++;
    end
    nvec++;
    if (cap_n != NW || bad != 0 || cap_done_cyc == 0) begin
      nfail++;
      $display("FAIL bp_stream: n=%0d wrong_words=%0d done_cyc=%0d, required n=%0d wrong=0 done seen",
               cap_n, bad, cap_done_cyc, NW);
    end
    nvec++;
    if (cap_stall_bad != 0) begin
      nfail++;
      $display("FAIL bp_stable: %0d data changes while stalled, required 0", cap_stall_bad);
    end
    nvec++;
    if (o_frame_cnt !== 2'd3) begin
      nfail++;
      $display("FAIL bp_cnt: got %0d, required 3", o_frame_cnt);
    end
    step();
  endtask

  task automatic test_err_and_midframe();
    int extra;
    i_start = 1'b1;
    i_oper  = 2'd3;
    step();
    i_start = 1'b0;
    nvec++;
    if (o_err !== 1'b1 || o_vld !== 1'b0) begin
      nfail++;
      $display("FAIL err_pulse: err=%b vld=%b, required 1 0", o_err, o_vld);
    end
    step();
    nvec++;
    if (o_err !== 1'b0 || o_vld !== 1'b0) begin
      nfail++;
      $display("FAIL err_single: err=%b vld=%b, required 0 0", o_err, o_vld);
    end
    do_start(2'd1, BCAST, 48'h0);
    capture(1'b0, 4);
    nvec++;
    if (cap_err_cnt != 0 || cap_n != NW || cap_done_cyc != NW + 1) begin
      nfail++;
      $display("FAIL midframe_start: err_pulses=%0d n=%0d done_cyc=%0d, required 0 %0d %0d",
               cap_err_cnt, cap_n, cap_done_cyc, NW, NW + 1);
    end
    nvec++;
    if (o_frame_cnt !== 2'd0) begin
      nfail++;
      $display("FAIL cnt_wrap: got %0d, required 0", o_frame_cnt);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_vld || o_err) extra++;
    end
    nvec++;
    if (extra != 0) begin
      nfail++;
      $display("FAIL midframe_noextra: %0d cycles with vld/err after frame, required 0", extra);
    end
  endtask

  task automatic test_reset_midframe();
    int dones;
    do_start(2'd1, BCAST, 48'h0);
    for (int i = 0; i < 5; i++) step();
    nvec++;
    if (o_data !== 32'h00010023) begin
      nfail++;
      $display("FAIL rst_at_w5: data=%h, required 00010023", o_data);
    end
    rst_n = 1'b0;
    step();
    nvec++;
    if ({o_data, o_vld, o_sop, o_eop, o_mod, o_busy, o_done, o_err, o_frame_cnt} !== '0) begin
      nfail++;
      $display("FAIL rst_midframe: data=%h vld=%b sop=%b eop=%b mod=%0d busy=%b done=%b err=%b cnt=%0d, all required 0",
               o_data, o_vld, o_sop, o_eop, o_mod, o_busy, o_done, o_err, o_frame_cnt);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_done || o_vld) dones++;
    end
    nvec++;
    if (dones != 0) begin
      nfail++;
      $display("FAIL rst_no_done: %0d cycles with done/vld after reset, required 0", dones);
    end
    do_start(2'd1, BCAST, 48'h0);
    nvec++;
    if (!(o_vld && o_sop) || o_data !== 32'hFFFFFFFF) begin
      nfail++;
      $display("FAIL rst_clean_sop: vld=%b sop=%b data=%h, required 1 1 ffffffff", o_vld, o_sop, o_data);
    end
    capture(1'b0, 0);
    nvec++;
    if (cap_n != NW || cap_data[10] !== REQ_W[10] || o_frame_cnt !== 2'd1) begin
      nfail++;
      $display("FAIL rst_clean_frame: n=%0d w10=%h cnt=%0d, required %0d %h 1",
               cap_n, cap_data[10], o_frame_cnt, NW, REQ_W[10]);
    end
  endtask

  // Entered in the DONE cycle of the previous frame
  task automatic test_back_to_back();
    nvec++;
    if (o_done !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_in_done: o_done=%b, required 1", o_done);
    end
    do_start(2'd2, PEER, PEER);
    nvec++;
    if (!(o_vld && o_sop) || o_data !== REP_W[0]) begin
      nfail++;
      $display("FAIL b2b_sop: vld=%b sop=%b data=%h, required 1 1 %h", o_vld, o_sop, o_data, REP_W[0]);
    end
    capture(1'b0, 0);
    nvec++;
    if (cap_n != NW || cap_data[8] !== REP_W[8] || cap_data[9] !== REP_W[9] || o_frame_cnt !== 2'd2) begin
      nfail++;
      $display("FAIL b2b_frame: n=%0d w8=%h w9=%h cnt=%0d, required %0d %h %h 2",
               cap_n, cap_data[8], cap_data[9], o_frame_cnt, NW, REP_W[8], REP_W[9]);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_request();
    test_reply();
    test_backpressure();
    test_err_and_midframe();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
